// File: rtl/button_capture_if.sv
// button_capture_if: groups the player-button capture signals.
// The master side is the game/driver; the slave side is the capture block.
interface button_capture_if;
    logic [3:0] buttons;
    logic       arm;
    logic [5:0] round_len;
    logic [3:0] player_input;
    logic       input_valid;
    logic [5:0] step;
    logic       round_done;
    logic       multi_err;
    logic       timeout;

    modport master (
        output buttons, arm, round_len,
        input  player_input, input_valid, step, round_done, multi_err, timeout
    );

    modport slave (
        input  buttons, arm, round_len,
        output player_input, input_valid, step, round_done, multi_err, timeout
    );
endinterface

// File: rtl/button_capture.sv
// button_capture: synchronizes and debounces four player buttons, and reports
// each accepted one-hot press with its index in the current round.
// Optional feature macro: TIMEOUT_EN enables the WAIT_PRESS inactivity timeout.
module button_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 50000
) (
    input logic             clk,
    input logic             reset,
    button_capture_if.slave bus
);

    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]       CNT_MAX = 6'd33;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        PRESS_DB,
        WAIT_RELEASE,
        RELEASE_DB,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0]      pattern_q, pattern_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [5:0]      press_cnt_q, press_cnt_d;
    logic [5:0]      len_q, len_d;
    logic [3:0]      player_input_q, player_input_d;
    logic [5:0]      step_q, step_d;
    logic            input_valid_q, input_valid_d;
    logic            round_done_q, round_done_d;
    logic            multi_err_q, multi_err_d;
    logic [5:0]      press_next;

`ifdef TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`else
    // The timeout length has no meaning when the timeout feature is absent.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Next-state logic: synchronizer shift, press/release debounce and round bookkeeping.
    always_comb begin
        sync1_d        = bus.buttons;
        sync2_d        = sync1_q;
        state_d        = state_q;
        pattern_d      = pattern_q;
        db_cnt_d       = db_cnt_q;
        press_cnt_d    = press_cnt_q;
        len_d          = len_q;
        player_input_d = player_input_q;
        step_d         = step_q;
        input_valid_d  = 1'b0;
        round_done_d   = 1'b0;
        multi_err_d    = 1'b0;
        press_next     = (press_cnt_q < CNT_MAX) ? press_cnt_q + 6'd1 : CNT_MAX;
`ifdef TIMEOUT_EN
        timeout_d      = 1'b0;
        to_cnt_d       = '0;
`endif

        if (!bus.arm) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = WAIT_PRESS;
                    len_d       = (bus.round_len == 6'd0) ? 6'd1 : bus.round_len;
                    press_cnt_d = '0;
                end

                WAIT_PRESS: begin
                    if (sync2_q != 4'd0) begin
                        state_d   = PRESS_DB;
                        pattern_d = sync2_q;
                        db_cnt_d  = '0;
                    end
`ifdef TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end

                PRESS_DB: begin
                    if (sync2_q != pattern_q) begin
                        if (sync2_q == 4'd0) begin
                            state_d = WAIT_PRESS;
                        end else begin
                            pattern_d = sync2_q;
                            db_cnt_d  = '0;
                        end
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d = WAIT_RELEASE;
                        if ($onehot(pattern_q)) begin
                            input_valid_d  = 1'b1;
                            player_input_d = pattern_q;
                            step_d         = press_cnt_q;
                            press_cnt_d    = press_next;
                            round_done_d   = (press_next == len_q);
                        end else begin
                            multi_err_d = 1'b1;
                        end
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end

                WAIT_RELEASE: begin
                    if (sync2_q == 4'd0) begin
                        state_d  = RELEASE_DB;
                        db_cnt_d = '0;
                    end
                end

                RELEASE_DB: begin
                    if (sync2_q != 4'd0) begin
                        state_d = WAIT_RELEASE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d = (press_cnt_q >= len_q) ? DONE : WAIT_PRESS;
                    end else begin
                        db_cnt_d = db_cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    state_d = DONE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            sync1_q        <= '0;
            sync2_q        <= '0;
            pattern_q      <= '0;
            db_cnt_q       <= '0;
            press_cnt_q    <= '0;
            len_q          <= '0;
            player_input_q <= '0;
            step_q         <= '0;
            input_valid_q  <= 1'b0;
            round_done_q   <= 1'b0;
            multi_err_q    <= 1'b0;
`ifdef TIMEOUT_EN
            to_cnt_q       <= '0;
            timeout_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            pattern_q      <= pattern_d;
            db_cnt_q       <= db_cnt_d;
            press_cnt_q    <= press_cnt_d;
            len_q          <= len_d;
            player_input_q <= player_input_d;
            step_q         <= step_d;
            input_valid_q  <= input_valid_d;
            round_done_q   <= round_done_d;
            multi_err_q    <= multi_err_d;
`ifdef TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            timeout_q      <= timeout_d;
`endif
        end
    end

    assign bus.player_input = player_input_q;
    assign bus.input_valid  = input_valid_q;
    assign bus.step         = step_q;
    assign bus.round_done   = round_done_q;
    assign bus.multi_err    = multi_err_q;
`ifdef TIMEOUT_EN
    assign bus.timeout      = timeout_q;
`else
    assign bus.timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_button_capture.sv
// tb_button_capture: self-checking bench for button_capture with
// DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=100. Honours TIMEOUT_EN if defined.
module tb_button_capture;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_MERR  = 3'b010;
    localparam logic [2:0] K_TO    = 3'b100;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] pi;
        logic [5:0] step;
        logic       rd;
    } ev_t;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        int         exp_valid;
        int         exp_merr;
        logic [3:0] exp_pi;
        logic [5:0] exp_step;
    } vec_t;

    logic clk;
    logic reset;
    int   n_compared;
    int   n_mismatch;
    ev_t  obs[$];
    ev_t  exp_q[$];
    logic [3:0] mdl_pi;
    logic [5:0] mdl_step;
    vec_t vecs[8];

    button_capture_if bus();

    button_capture #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every pulse the DUT emits, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.input_valid || bus.multi_err || bus.timeout || bus.round_done)
            obs.push_back('{kind: {bus.timeout, bus.multi_err, bus.input_valid},
                            pi: bus.player_input, step: bus.step, rd: bus.round_done});
    end

    // Hard stop in case something stalls the main sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] b, input int cycles);
        bus.buttons = b;
        waitCycles(cycles);
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int gap);
        applyStimulus(b, hold);
        applyStimulus(4'd0, gap);
    endtask

    task automatic startRound(input logic [5:0] len);
        bus.buttons = 4'd0;
        bus.arm     = 1'b0;
        waitCycles(3);
        bus.round_len = len;
        bus.arm       = 1'b1;
        waitCycles(2);
    endtask

    task automatic doReset();
        reset       = 1'b1;
        bus.arm     = 1'b0;
        bus.buttons = 4'd0;
        waitCycles(2);
        reset = 1'b0;
        waitCycles(1);
        obs.delete();
        mdl_pi   = 4'd0;
        mdl_step = 6'd0;
    endtask

    function automatic ev_t mkEv(logic [2:0] k, logic [3:0] pi, logic [5:0] st, logic rd);
        ev_t e;
        e.kind = k;
        e.pi   = pi;
        e.step = st;
        e.rd   = rd;
        return e;
    endfunction

    task automatic expectEvents(input string name, input ev_t exp[$]);
        checkOutput({name, " event count"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++)
            checkOutput($sformatf("%s event %0d", name, i), int'(obs[i]), int'(exp[i]));
        obs.delete();
    endtask

    task automatic countEvents(output int nv, output int nm);
        nv = 0;
        nm = 0;
        foreach (obs[i]) begin
            if (obs[i].kind == K_VALID) nv++;
            if (obs[i].kind == K_MERR)  nm++;
        end
        obs.delete();
    endtask

    // One armed round of random presses, predicted from the round rules alone.
    task automatic randomRound(input logic [5:0] len, input int n_press);
        int         acc;
        int         len_eff;
        bit         done;
        logic [3:0] p;
        exp_q.delete();
        acc     = 0;
        done    = 1'b0;
        len_eff = (len == 6'd0) ? 1 : int'(len);
        startRound(len);
        obs.delete();
        for (int i = 0; i < n_press; i++) begin
            if ($urandom_range(3) == 0) begin
                do p = 4'($urandom_range(15)); while ($countones(p) < 2);
            end else begin
                p = 4'(1 << $urandom_range(3));
            end
            if (!done) begin
                if ($countones(p) == 1) begin
                    mdl_pi   = p;
                    mdl_step = 6'(acc);
                    acc      = (acc < 33) ? acc + 1 : 33;
                    done     = (acc == len_eff);
                    exp_q.push_back(mkEv(K_VALID, mdl_pi, mdl_step, done));
                end else begin
                    exp_q.push_back(mkEv(K_MERR, mdl_pi, mdl_step, 1'b0));
                end
            end
            press(p, $urandom_range(5, 12), $urandom_range(5, 12));
        end
        waitCycles(4);
        expectEvents($sformatf("random len=%0d", len), exp_q);
    endtask

    initial begin
        int nv;
        int nm;
        n_compared    = 0;
        n_mismatch    = 0;
        reset         = 1'b1;
        bus.buttons   = 4'd0;
        bus.arm       = 1'b0;
        bus.round_len = 6'd0;

        vecs[0] = '{4'b0001, 10, 1, 0, 4'b0001, 6'd0};
        vecs[1] = '{4'b0010, 10, 1, 0, 4'b0010, 6'd1};
        vecs[2] = '{4'b0011, 10, 0, 1, 4'b0010, 6'd1};
        vecs[3] = '{4'b0100,  3, 0, 0, 4'b0010, 6'd1};
        vecs[4] = '{4'b1000,  5, 1, 0, 4'b1000, 6'd2};
        vecs[5] = '{4'b0100,  4, 0, 0, 4'b1000, 6'd2};
        vecs[6] = '{4'b1111,  6, 0, 1, 4'b1000, 6'd2};
        vecs[7] = '{4'b0100,  8, 1, 0, 4'b0100, 6'd3};

        // Reset values.
        waitCycles(3);
        checkOutput("reset player_input", bus.player_input, 0);
        checkOutput("reset step",         bus.step,         0);
        checkOutput("reset input_valid",  bus.input_valid,  0);
        checkOutput("reset round_done",   bus.round_done,   0);
        checkOutput("reset multi_err",    bus.multi_err,    0);
        checkOutput("reset timeout",      bus.timeout,      0);
        reset = 1'b0;
        waitCycles(2);
        obs.delete();

        // Three-press round, then a press in DONE that must be ignored.
        startRound(6'd3);
        obs.delete();
        press(4'b0001, 10, 10);
        press(4'b0100, 10, 10);
        press(4'b1000, 10, 10);
        waitCycles(2);
        exp_q = '{mkEv(K_VALID, 4'b0001, 6'd0, 1'b0),
                  mkEv(K_VALID, 4'b0100, 6'd1, 1'b0),
                  mkEv(K_VALID, 4'b1000, 6'd2, 1'b1)};
        expectEvents("round of 3", exp_q);
        press(4'b0010, 10, 10);
        exp_q.delete();
        expectEvents("press in DONE", exp_q);

        // Table of single presses, including debounce length boundaries.
        startRound(6'd33);
        obs.delete();
        foreach (vecs[i]) begin
            press(vecs[i].btn, vecs[i].hold, 8);
            countEvents(nv, nm);
            checkOutput($sformatf("vec%0d valid count", i), nv, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d multi_err count", i), nm, vecs[i].exp_merr);
            checkOutput($sformatf("vec%0d player_input", i), bus.player_input, vecs[i].exp_pi);
            checkOutput($sformatf("vec%0d step", i), bus.step, vecs[i].exp_step);
        end

        // Bouncing 0010 settling into a clean press.
        startRound(6'd5);
        obs.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0010, 2);
            applyStimulus(4'b0000, 2);
        end
        press(4'b0010, 10, 10);
        exp_q = '{mkEv(K_VALID, 4'b0010, 6'd0, 1'b0)};
        expectEvents("bounce", exp_q);

        // Arm dropped mid-round, then a fresh two-press round.
        startRound(6'd3);
        obs.delete();
        press(4'b0001, 10, 10);
        bus.arm = 1'b0;
        waitCycles(3);
        checkOutput("arm drop player_input held", bus.player_input, 4'b0001);
        checkOutput("arm drop step held", bus.step, 0);
        exp_q = '{mkEv(K_VALID, 4'b0001, 6'd0, 1'b0)};
        expectEvents("before arm drop", exp_q);
        bus.round_len = 6'd2;
        bus.arm       = 1'b1;
        waitCycles(2);
        press(4'b0010, 10, 10);
        press(4'b0100, 10, 10);
        press(4'b1000, 10, 10);
        exp_q = '{mkEv(K_VALID, 4'b0010, 6'd0, 1'b0),
                  mkEv(K_VALID, 4'b0100, 6'd1, 1'b1)};
        expectEvents("re-armed round", exp_q);

`ifdef TIMEOUT_EN
        // Inactivity timeout fires once and parks the round.
        startRound(6'd3);
        obs.delete();
        waitCycles(88);
        checkOutput("no early timeout", obs.size(), 0);
        waitCycles(20);
        exp_q = '{mkEv(K_TO, 4'b0100, 6'd1, 1'b0)};
        expectEvents("timeout", exp_q);
        press(4'b0001, 10, 10);
        waitCycles(110);
        exp_q.delete();
        expectEvents("after timeout", exp_q);
`else
        // Without the timeout feature the round waits indefinitely.
        startRound(6'd3);
        obs.delete();
        waitCycles(110);
        checkOutput("timeout output", bus.timeout, 0);
        exp_q.delete();
        expectEvents("long idle", exp_q);
        press(4'b0001, 10, 10);
        exp_q = '{mkEv(K_VALID, 4'b0001, 6'd0, 1'b0)};
        expectEvents("press after long idle", exp_q);
`endif

        // Reset in the middle of debouncing a press.
        startRound(6'd5);
        obs.delete();
        press(4'b0001, 10, 10);
        press(4'b0010, 10, 10);
        bus.buttons = 4'b0100;
        waitCycles(5);
        reset       = 1'b1;
        bus.buttons = 4'd0;
        waitCycles(1);
        checkOutput("mid reset player_input", bus.player_input, 0);
        checkOutput("mid reset step",         bus.step,         0);
        checkOutput("mid reset input_valid",  bus.input_valid,  0);
        checkOutput("mid reset round_done",   bus.round_done,   0);
        checkOutput("mid reset multi_err",    bus.multi_err,    0);
        reset = 1'b0;
        waitCycles(20);
        exp_q = '{mkEv(K_VALID, 4'b0001, 6'd0, 1'b0),
                  mkEv(K_VALID, 4'b0010, 6'd1, 1'b0)};
        expectEvents("press discarded by reset", exp_q);
        press(4'b1000, 10, 10);
        exp_q = '{mkEv(K_VALID, 4'b1000, 6'd0, 1'b0)};
        expectEvents("press after reset", exp_q);

        // Random rounds: zero length, saturating counter, then short rounds.
        doReset();
        randomRound(6'd0, 3);
        randomRound(6'd40, 36);
        for (int r = 0; r < 20; r++)
            randomRound(6'($urandom_range(1, 6)), $urandom_range(1, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/button_capture.md
BUTTON_CAPTURE -- requirements
Module: button_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a press or release edge.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle cycles allowed between presses before timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 buttons  input  4  raw asynchronous player buttons, active-high, bit n = colour n.
REQ-006 arm  input  1  level from game FSM; high = accept presses for the current round.
REQ-007 round_len  input  6  presses expected this round, 1..33; sampled when arm rises.
REQ-008 player_input  output  4  one-hot colour of the last accepted press; held until the next accept.
REQ-009 input_valid  output  1  one-cycle pulse when player_input updates.
REQ-010 step  output  6  zero-based index of the last accepted press within the round.
REQ-011 round_done  output  1  one-cycle pulse when accepted presses equal the latched round_len.
REQ-012 multi_err  output  1  one-cycle pulse when a debounced press has more than one bit set.
REQ-013 timeout  output  1  one-cycle pulse on inactivity expiry (TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-014 SHALL pass buttons through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-015 States SHALL be IDLE, WAIT_PRESS, PRESS_DB, WAIT_RELEASE, RELEASE_DB, DONE.
REQ-016 IDLE -> WAIT_PRESS on the cycle arm is first seen high; that cycle latches round_len and clears the press counter.
REQ-017 WAIT_PRESS -> PRESS_DB when synchronized buttons != 0; the pattern is captured and the debounce counter cleared.
REQ-018 PRESS_DB: if the pattern changes, return to WAIT_PRESS (pattern 0) or restart debounce with the new pattern (pattern nonzero).
REQ-019 PRESS_DB: after DEBOUNCE_CYCLES stable cycles with a one-hot pattern -> WAIT_RELEASE; next cycle input_valid=1, player_input=pattern, step=counter, counter++.
REQ-020 PRESS_DB: after DEBOUNCE_CYCLES stable cycles with a multi-bit pattern -> WAIT_RELEASE; multi_err pulses; no input_valid; counter unchanged.
REQ-021 WAIT_RELEASE -> RELEASE_DB when synchronized buttons == 0; RELEASE_DB -> WAIT_PRESS after DEBOUNCE_CYCLES cycles of zero; any nonzero returns to WAIT_RELEASE.
REQ-022 When the accepted count reaches the latched round_len, round_done SHALL pulse in the same cycle as that input_valid; the state goes to DONE after release debounce instead of WAIT_PRESS.
REQ-023 DONE -> IDLE when arm is low; further presses in DONE are ignored.
REQ-024 Deassertion of arm in any state SHALL return to IDLE next cycle with no pulses; player_input and step retain their values.
REQ-025 The press counter SHALL be 6 bits and saturate at 33; a round_len of 0 latched SHALL be treated as 1.
REQ-026 At most one of input_valid, multi_err, timeout SHALL assert in any cycle.

Reset
REQ-027 reset SHALL force IDLE; player_input=0, step=0, all pulses 0, synchronizer, counters and latched round_len all 0.
REQ-028 reset asserted mid-press SHALL discard the press; no input_valid after reset deasserts until a fresh full debounce.

Configuration
REQ-029 With TIMEOUT_EN defined: a counter runs in WAIT_PRESS only, clears on entry; at TIMEOUT_CYCLES it pulses timeout once and goes to DONE.
REQ-030 Without TIMEOUT_EN: no timeout counter is synthesized, timeout is constant 0, and WAIT_PRESS waits indefinitely.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
REQ-031 reset, arm=1, round_len=3, presses 0001, 0100, 1000 each held 10 cycles -> three input_valid pulses, step 0,1,2, round_done with the third pulse.
REQ-032 buttons=0010 bouncing (toggles every 2 cycles for 12 cycles, then stable) -> exactly one input_valid, player_input=0010.
REQ-033 buttons=0011 held 10 cycles -> one multi_err pulse, no input_valid, step unchanged.
REQ-034 TIMEOUT_EN, arm=1, no press for 100 cycles -> single timeout pulse, state DONE; without macro -> timeout stays 0.
REQ-035 reset asserted during PRESS_DB of 0100 -> all outputs 0 next cycle; no input_valid afterwards until a new press.
REQ-036 arm dropped after 1 of 3 presses, then re-raised with round_len=2 -> step restarts at 0, round_done after the 2nd press.
